// File: rtl/vga_menu_engine.sv
// vga_menu_engine
// Menu renderer and controller for the VGA path. It holds a writable glyph
// table of NUM_OPTIONS text rows and runs the selection state machine (key edge
// detection, wrap/saturate navigation, confirm pulse). For every pixel it
// produces the font/image ROM read address and overlays the screen border and
// the selection box on the colour index that comes back from the palette ROM.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   menu_enable         menu screen active
//   key_up/down/select  raw key levels, synchronous to clock
//   char_we/waddr/wdata glyph table write port (slot = row*CHARS_PER_OPTION+col)
//   curAddress          pixel address y*640 + x from the VGA counter
//   indexIn             colour index returned by the palette ROM
//   addrToRead          ROM read address, 2 cycles after curAddress
//   indexOut            final colour index (combinational on indexIn)
//   selection           current menu row
//   select_valid        one-cycle confirm pulse
//   menu_state          0 IDLE, 1 ACTIVE, 2 CONFIRMED
module vga_menu_engine #(
  parameter int unsigned NUM_OPTIONS      = 4,
  parameter int unsigned CHARS_PER_OPTION = 7,
  parameter int unsigned GLYPH_W          = 21,
  parameter int unsigned GLYPH_H          = 25,
  parameter int unsigned OPT_X0           = 246,
  parameter int unsigned OPT_Y0           = 227,
  parameter int unsigned OPT_PITCH        = 58,
  parameter int unsigned FONT_BASE        = 307200,
  parameter int unsigned BG_ADDR          = 1923,
  parameter int unsigned BORDER_INDEX     = 7,
  parameter int unsigned WRAP             = 1
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              menu_enable,
  input  logic                                              key_up,
  input  logic                                              key_down,
  input  logic                                              key_select,
  input  logic                                              char_we,
  input  logic [$clog2(NUM_OPTIONS*CHARS_PER_OPTION)-1:0]   char_waddr,
  input  logic [4:0]                                        char_wdata,
  input  logic [18:0]                                       curAddress,
  input  logic [7:0]                                        indexIn,
  output logic [18:0]                                       addrToRead,
  output logic [7:0]                                        indexOut,
  output logic [$clog2(NUM_OPTIONS)-1:0]                    selection,
  output logic                                              select_valid,
  output logic [1:0]                                        menu_state
);

  localparam int unsigned Slots    = NUM_OPTIONS * CHARS_PER_OPTION;
  localparam int unsigned SlotW    = $clog2(Slots);
  localparam int unsigned SelW     = $clog2(NUM_OPTIONS);
  localparam int unsigned CoordW   = 11;
  localparam int unsigned AddrW    = 19;
  localparam int unsigned CodeW    = 5;
  localparam int unsigned DxW      = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned DyW      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned ScreenW  = 640;
  localparam int unsigned ScreenH  = 480;
  localparam int unsigned FramePx  = 3;
  localparam int unsigned TextW    = CHARS_PER_OPTION * GLYPH_W;
  localparam int unsigned BoxW     = TextW + 2 * FramePx;
  localparam int unsigned BoxH     = GLYPH_H + 2 * FramePx;

  localparam logic [CodeW-1:0]  BlankCode = CodeW'(31);
  localparam logic [SelW-1:0]   SelMax    = SelW'(NUM_OPTIONS - 1);
  localparam logic [CoordW-1:0] TextX0    = CoordW'(OPT_X0);
  localparam logic [CoordW-1:0] TextX1    = CoordW'(OPT_X0 + TextW);
  localparam logic [CoordW-1:0] BoxX0     = CoordW'(OPT_X0 - FramePx);
  localparam logic [CoordW-1:0] BoxX1     = CoordW'(OPT_X0 - FramePx + BoxW);
  localparam logic [CoordW-1:0] InnerX0   = CoordW'(OPT_X0);
  localparam logic [CoordW-1:0] InnerX1   = CoordW'(OPT_X0 + TextW);
  localparam logic [CoordW-1:0] EdgeLo    = CoordW'(FramePx);
  localparam logic [CoordW-1:0] EdgeXHi   = CoordW'(ScreenW - FramePx);
  localparam logic [CoordW-1:0] EdgeYHi   = CoordW'(ScreenH - FramePx);
  localparam logic [AddrW-1:0]  BgAddr    = AddrW'(BG_ADDR);

  typedef enum logic [1:0] {
    stIdle      = 2'd0,
    stActive    = 2'd1,
    stConfirmed = 2'd2
  } menuStateT;

  menuStateT       state, stateNext;
  logic [SelW-1:0] selectionNext;
  logic            selectValidNext;

  // Key history and single-cycle edge detection
  logic upPrev, downPrev, selectPrev;
  logic upEdge, downEdge, selectEdge;
  logic navUp, navDown;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upPrev     <= 1'b0;
      downPrev   <= 1'b0;
      selectPrev <= 1'b0;
    end else begin
      upPrev     <= key_up;
      downPrev   <= key_down;
      selectPrev <= key_select;
    end
  end

  assign upEdge     = key_up & ~upPrev;
  assign downEdge   = key_down & ~downPrev;
  assign selectEdge = key_select & ~selectPrev;
  // Simultaneous up and down edges cancel each other
  assign navUp      = upEdge & ~downEdge;
  assign navDown    = downEdge & ~upEdge;

  // Menu state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= stIdle;
      selection    <= '0;
      select_valid <= 1'b0;
    end else begin
      state        <= stateNext;
      selection    <= selectionNext;
      select_valid <= selectValidNext;
    end
  end

  // Next state: disable beats confirm, confirm beats navigation
  always_comb begin
    stateNext       = state;
    selectionNext   = selection;
    selectValidNext = 1'b0;
    unique case (state)
      stIdle: begin
        if (menu_enable) begin
          stateNext     = stActive;
          selectionNext = '0;
        end
      end
      stActive: begin
        if (!menu_enable) begin
          stateNext = stIdle;
        end else if (selectEdge) begin
          stateNext       = stConfirmed;
          selectValidNext = 1'b1;
        end else if (navDown) begin
          if (selection == SelMax) begin
            selectionNext = (WRAP != 0) ? '0 : SelMax;
          end else begin
            selectionNext = selection + SelW'(1);
          end
        end else if (navUp) begin
          if (selection == '0) begin
            selectionNext = (WRAP != 0) ? SelMax : '0;
          end else begin
            selectionNext = selection - SelW'(1);
          end
        end
      end
      stConfirmed: begin
        if (!menu_enable) begin
          stateNext = stIdle;
        end
      end
      default: begin
        stateNext = stIdle;
      end
    endcase
  end

  assign menu_state = state;

  // Glyph table; out-of-range slot addresses are dropped
  logic [CodeW-1:0] glyphTable [Slots];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Slots; i++) begin
        glyphTable[i] <= BlankCode;
      end
    end else if (char_we && (32'(char_waddr) < Slots)) begin
      glyphTable[char_waddr] <= char_wdata;
    end
  end

  // Pixel coordinates
  logic [CoordW-1:0] pixX, pixY;
  assign pixX = CoordW'(curAddress % 19'd640);
  assign pixY = CoordW'(curAddress / 19'd640);

  // Stage 1 glyph lookup: which row/column the pixel lands in
  logic [CoordW-1:0] xOff, colIdx, rowTop;
  logic              glyphHitC;
  logic [CodeW-1:0]  codeC;
  logic [DxW-1:0]    dxC;
  logic [DyW-1:0]    dyC;

  always_comb begin
    glyphHitC = 1'b0;
    codeC     = BlankCode;
    dxC       = '0;
    dyC       = '0;
    rowTop    = '0;
    xOff      = pixX - TextX0;
    colIdx    = xOff / CoordW'(GLYPH_W);
    for (int r = 0; r < NUM_OPTIONS; r++) begin
      rowTop = CoordW'(OPT_Y0 + r * OPT_PITCH);
      if ((pixY >= rowTop) && (pixY < rowTop + CoordW'(GLYPH_H)) &&
          (pixX >= TextX0) && (pixX < TextX1)) begin
        glyphHitC = 1'b1;
        dxC       = DxW'(xOff % CoordW'(GLYPH_W));
        dyC       = DyW'(pixY - rowTop);
        codeC     = glyphTable[SlotW'(r * CHARS_PER_OPTION) + SlotW'(colIdx)];
      end
    end
  end

  // Stage 1 overlay: screen border plus selection-box frame
  logic [CoordW-1:0] boxY0;
  logic              borderC, inBox, inInner, frameC, flagC;

  always_comb begin
    boxY0   = CoordW'(OPT_Y0 - FramePx) + CoordW'(selection) * CoordW'(OPT_PITCH);
    borderC = (pixY < EdgeLo) || (pixY >= EdgeYHi) ||
              (pixX < EdgeLo) || (pixX >= EdgeXHi);
    inBox   = (pixX >= BoxX0) && (pixX < BoxX1) &&
              (pixY >= boxY0) && (pixY < boxY0 + CoordW'(BoxH));
    inInner = (pixX >= InnerX0) && (pixX < InnerX1) &&
              (pixY >= boxY0 + CoordW'(FramePx)) &&
              (pixY < boxY0 + CoordW'(BoxH - FramePx));
    frameC  = (state != stIdle) && inBox && !inInner;
    flagC   = borderC || frameC;
  end

  // Pipeline registers
  logic             s1Hit;
  logic [CodeW-1:0] s1Code;
  logic [DxW-1:0]   s1Dx;
  logic [DyW-1:0]   s1Dy;
  logic             ovFlag1, ovFlag2, ovFlag3;
  logic [AddrW-1:0] fontAddrC;

  assign fontAddrC = AddrW'(FONT_BASE)
                   + AddrW'(s1Code) * AddrW'(GLYPH_W * GLYPH_H)
                   + AddrW'(s1Dx)
                   + AddrW'(s1Dy) * AddrW'(GLYPH_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Hit      <= 1'b0;
      s1Code     <= '0;
      s1Dx       <= '0;
      s1Dy       <= '0;
      ovFlag1    <= 1'b0;
      ovFlag2    <= 1'b0;
      ovFlag3    <= 1'b0;
      addrToRead <= BgAddr;
    end else begin
      // Glyphs only render while the menu is up
      s1Hit      <= glyphHitC && (state != stIdle);
      s1Code     <= codeC;
      s1Dx       <= dxC;
      s1Dy       <= dyC;
      ovFlag1    <= flagC;
      ovFlag2    <= ovFlag1;
      ovFlag3    <= ovFlag2;
      addrToRead <= (s1Hit && (s1Code != BlankCode)) ? fontAddrC : BgAddr;
    end
  end

  // Third flag stage lines up with the palette ROM's one-cycle latency
  assign indexOut = ovFlag3 ? 8'(BORDER_INDEX) : indexIn;

endmodule

// File: tb/tb_vga_menu_engine.sv
// Directed bench for vga_menu_engine: one wrapping and one saturating
// instance share all inputs; expected values are hand-computed constants.
module tb_vga_menu_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        menu_enable, key_up, key_down, key_select, char_we;
  logic [4:0]  char_waddr;
  logic [4:0]  char_wdata;
  logic [18:0] curAddress;
  logic [7:0]  indexIn;

  logic [18:0] addrToRead, satAddr;
  logic [7:0]  indexOut, satIndex;
  logic [1:0]  selection, satSel;
  logic        select_valid, satValid;
  logic [1:0]  menu_state, satState;

  int nAsserts  = 0;
  int nFailures = 0;

  always #5 clock = ~clock;

  vga_menu_engine #(.WRAP(1)) dut (
    .clock(clock), .reset(reset), .menu_enable(menu_enable),
    .key_up(key_up), .key_down(key_down), .key_select(key_select),
    .char_we(char_we), .char_waddr(char_waddr), .char_wdata(char_wdata),
    .curAddress(curAddress), .indexIn(indexIn),
    .addrToRead(addrToRead), .indexOut(indexOut), .selection(selection),
    .select_valid(select_valid), .menu_state(menu_state)
  );

  vga_menu_engine #(.WRAP(0)) dutSat (
    .clock(clock), .reset(reset), .menu_enable(menu_enable),
    .key_up(key_up), .key_down(key_down), .key_select(key_select),
    .char_we(char_we), .char_waddr(char_waddr), .char_wdata(char_wdata),
    .curAddress(curAddress), .indexIn(indexIn),
    .addrToRead(satAddr), .indexOut(satIndex), .selection(satSel),
    .select_valid(satValid), .menu_state(satState)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFailures++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pressDown();
    key_down = 1'b1; tick();
    key_down = 1'b0; tick();
  endtask

  task automatic pressUp();
    key_up = 1'b1; tick();
    key_up = 1'b0; tick();
  endtask

  task automatic setPixel(input int x, input int y);
    curAddress = 19'(y * 640 + x);
  endtask

  // Present a pixel, wait for the overlay latency, then drive the ROM index
  task automatic showPixel(input int x, input int y, input logic [7:0] idx);
    setPixel(x, y);
    repeat (3) tick();
    indexIn = idx;
    #1;
  endtask

  int expWrap [5] = '{1, 2, 3, 0, 1};
  int expSat  [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1; menu_enable = 1'b0; key_up = 1'b0; key_down = 1'b0;
    key_select = 1'b0; char_we = 1'b0; char_waddr = '0; char_wdata = '0;
    curAddress = '0; indexIn = '0;
    repeat (3) tick();

    // 1. Reset mid-frame
    reset = 1'b0; menu_enable = 1'b1; tick();
    pressDown();
    setPixel(300, 150); tick();
    #3 reset = 1'b1; #1;
    check("rst_async_state", 32'(menu_state), 0);
    check("rst_async_sel", 32'(selection), 0);
    check("rst_async_addr", 32'(addrToRead), 1923);
    check("rst_async_valid", 32'(select_valid), 0);
    menu_enable = 1'b0; tick();
    reset = 1'b0; tick();
    check("rst_rel_state", 32'(menu_state), 0);
    showPixel(100, 100, 8'h22);
    check("rst_passthru_idx", 32'(indexOut), 32'h22);
    check("rst_idle_addr", 32'(addrToRead), 1923);

    // 2. Navigation, wrap vs saturate, held key
    menu_enable = 1'b1; tick();
    check("enable_state", 32'(menu_state), 1);
    check("enable_sel", 32'(selection), 0);
    for (int i = 0; i < 5; i++) begin
      pressDown();
      check($sformatf("wrap_down%0d", i), 32'(selection), 32'(expWrap[i]));
      check($sformatf("sat_down%0d", i), 32'(satSel), 32'(expSat[i]));
    end
    key_down = 1'b1; repeat (50) tick();
    key_down = 1'b0; tick();
    check("held_down_wrap", 32'(selection), 2);
    check("held_down_sat", 32'(satSel), 3);

    // 3. Glyph address generation
    char_we = 1'b1; char_waddr = 5'd0; char_wdata = 5'd12; tick();
    char_we = 1'b0;
    setPixel(246, 227); tick(); tick();
    check("glyph_origin", 32'(addrToRead), 313500);
    check("glyph_origin_sat", 32'(satAddr), 313500);
    setPixel(250, 230); tick(); tick();
    check("glyph_offset", 32'(addrToRead), 313567);
    setPixel(267, 227); tick(); tick();
    check("glyph_blank_slot", 32'(addrToRead), 1923);
    setPixel(245, 227); tick(); tick();
    check("glyph_left_edge", 32'(addrToRead), 1923);
    setPixel(246, 251); tick(); tick();
    check("glyph_last_line", 32'(addrToRead), 314004);
    setPixel(246, 252); tick();
    check("glyph_latency1", 32'(addrToRead), 314004);
    tick();
    check("glyph_below_row", 32'(addrToRead), 1923);

    // 4. Overlay with selection 1
    pressUp();
    check("up_wrap", 32'(selection), 1);
    check("up_sat", 32'(satSel), 2);
    setPixel(244, 290); tick();
    setPixel(300, 100); tick(); tick();
    indexIn = 8'h55; #1;
    check("box_frame_left", 32'(indexOut), 7);
    check("box_other_sel", 32'(satIndex), 32'h55);
    tick();
    check("box_next_pixel", 32'(indexOut), 32'h55);
    showPixel(260, 290, 8'h41);
    check("box_inside", 32'(indexOut), 32'h41);
    showPixel(1, 200, 8'h41);
    check("border_left", 32'(indexOut), 7);
    showPixel(243, 282, 8'h12);
    check("box_corner", 32'(indexOut), 7);
    showPixel(246, 285, 8'h12);
    check("box_inner_corner", 32'(indexOut), 32'h12);
    showPixel(395, 300, 8'h13);
    check("box_right_col", 32'(indexOut), 7);
    showPixel(396, 300, 8'h13);
    check("box_right_outside", 32'(indexOut), 32'h13);
    showPixel(320, 479, 8'h14);
    check("border_bottom", 32'(indexOut), 7);

    // 5. Simultaneous up and down
    key_up = 1'b1; key_down = 1'b1; tick();
    key_up = 1'b0; key_down = 1'b0; tick();
    check("updown_wrap", 32'(selection), 1);
    check("updown_sat", 32'(satSel), 2);

    // 6. Confirm handshake
    key_select = 1'b1; key_down = 1'b1; tick();
    check("confirm_valid", 32'(select_valid), 1);
    check("confirm_state", 32'(menu_state), 2);
    check("confirm_sel", 32'(selection), 1);
    key_select = 1'b0; key_down = 1'b0; tick();
    check("confirm_pulse_end", 32'(select_valid), 0);
    pressDown();
    check("confirmed_frozen", 32'(selection), 1);
    check("confirmed_state", 32'(menu_state), 2);
    menu_enable = 1'b0; tick();
    check("disable_idle", 32'(menu_state), 0);
    setPixel(246, 227); tick(); tick();
    check("idle_bg_addr", 32'(addrToRead), 1923);
    menu_enable = 1'b1; tick();
    check("reenable_state", 32'(menu_state), 1);
    check("reenable_sel", 32'(selection), 0);
    key_select = 1'b1; tick();
    check("confirm2_valid", 32'(select_valid), 1);
    #2 reset = 1'b1; #1;
    check("rst_confirmed_state", 32'(menu_state), 0);
    check("rst_confirmed_valid", 32'(select_valid), 0);
    key_select = 1'b0; tick();
    reset = 1'b0; tick();
    setPixel(246, 227); tick(); tick();
    check("rst_glyph_cleared", 32'(addrToRead), 1923);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule

// File: doc/vga_menu_engine.md
Name: vga_menu_engine

Overview:
- Parametrised, pipelined menu renderer and controller for the VGA path; replaces fixed-layout main-menu pixel processors.
- Holds NUM_OPTIONS text rows in a writable glyph table and owns the selection state machine: key edge detection, wrap/saturate navigation, confirm handshake.
- Per pixel it generates the font-ROM read address and overlays the screen border and selection box onto the colour index returned by the palette ROM.
- Sits between the VGA address counter, the font/image ROM and the colour-index mux.

Parameters:
- NUM_OPTIONS, 4, menu rows (2..8)
- CHARS_PER_OPTION, 7, glyph slots per row
- GLYPH_W, 21, glyph width px
- GLYPH_H, 25, glyph height px
- OPT_X0, 246, x of first glyph column
- OPT_Y0, 227, y of row 0
- OPT_PITCH, 58, vertical row spacing px
- FONT_BASE, 307200, ROM address of glyph code 0
- BG_ADDR, 1923, ROM address of background pixel
- BORDER_INDEX, 7, overlay colour index
- WRAP, 1, 1 = navigation wraps; 0 = saturates at ends

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- menu_enable  in  1  menu screen active
- key_up  in  1  raw level, synchronous to clock
- key_down  in  1  raw level
- key_select  in  1  raw level
- char_we  in  1  glyph table write strobe
- char_waddr  in  clog2(NUM_OPTIONS*CHARS_PER_OPTION)  slot = row*CHARS_PER_OPTION + column
- char_wdata  in  5  glyph code; 31 = blank
- curAddress  in  19  pixel address, y*640 + x
- indexIn  in  8  colour index from palette ROM
- addrToRead  out  19  ROM read address
- indexOut  out  8  final colour index
- selection  out  clog2(NUM_OPTIONS)  current row
- select_valid  out  1  one-cycle confirm pulse
- menu_state  out  2  0 IDLE, 1 ACTIVE, 2 CONFIRMED

Behaviour:
- Reset (async): state IDLE; selection 0; select_valid 0; key history 0; all glyph slots 31; pipeline regs cleared; addrToRead = BG_ADDR; overlay flags 0, so indexOut = indexIn.
- Key edges: an edge exists in a cycle where the key is high and its registered previous value is low. A held key produces one edge.
- If the up and down edges fall in the same cycle, both are ignored.
- FSM:
  - IDLE: menu_enable=1 -> ACTIVE; selection loaded with 0.
  - ACTIVE:
    - down edge: selection+1. At NUM_OPTIONS-1 it goes to 0 if WRAP, otherwise holds.
    - up edge: selection-1. At 0 it goes to NUM_OPTIONS-1 if WRAP, otherwise holds.
    - select edge -> CONFIRMED; select_valid=1 for exactly that one cycle.
    - menu_enable=0 -> IDLE.
    - Priority: menu_enable=0 over select over navigation.
  - CONFIRMED: all keys ignored; selection frozen; menu_enable=0 -> IDLE.
- Glyph table: synchronous write, effective the next cycle. Reads are combinational inside stage 1. Writes are accepted in every state.
- Pixel pipeline; x = curAddress mod 640, y = curAddress / 640:
  - Stage 1 (register): row hit when OPT_Y0 + r*OPT_PITCH <= y < that + GLYPH_H and OPT_X0 <= x < OPT_X0 + CHARS_PER_OPTION*GLYPH_W. Registers column, dx, dy and the glyph code.
  - Stage 2 (register, drives addrToRead):
    - Glyph hit with code != 31: addrToRead = FONT_BASE + code*GLYPH_W*GLYPH_H + dx + dy*GLYPH_W, computed in 19 bits.
    - Otherwise: addrToRead = BG_ADDR.
  - addrToRead latency is 2 cycles from curAddress.
  - In IDLE every pixel maps to BG_ADDR.
- Overlay: the flag is computed in stage 1 and delayed so it is applied 3 cycles after curAddress, matching the 1-cycle ROM latency. indexOut = flag ? BORDER_INDEX : indexIn, combinational on indexIn.
  - Screen border: y<3, y>476, x<3 or x>636. Applies in all states.
  - Selection box (ACTIVE and CONFIRMED only):
    - Box origin: BX = OPT_X0-3, BY = OPT_Y0-3 + selection*OPT_PITCH.
    - Box size: W = CHARS_PER_OPTION*GLYPH_W + 6, H = GLYPH_H + 6.
    - Frame: 3-px thick outline of that rectangle; pixels inside it keep indexIn.
  - The selection used for a pixel is the value sampled at stage 1. A change mid-frame takes effect from that pixel onward.
- Reset mid-operation: state, selection and glyph table revert immediately; outputs take their reset values with no pulse.

Test Plan:
1. Assert reset mid-frame, then release -> menu_state 0, selection 0, addrToRead 1923, select_valid 0. Drive indexIn=0x22 at pixel (100,100) -> indexOut 0x22.
2. menu_enable=1, five separate key_down presses, WRAP=1 -> selection 1,2,3,0,1. With WRAP=0 -> 1,2,3,3,3. key_down held high for 50 cycles -> exactly one increment.
3. Write slot 0 = 12. curAddress 145526 (246,227) -> addrToRead 313500 after 2 cycles. curAddress 147450 (250,230) -> 313567. A slot holding 31 -> 1923.
4. selection=1, ACTIVE:
   - pixel (244,290) -> indexOut 7 three cycles later regardless of indexIn.
   - pixel (260,290) -> indexOut = indexIn.
   - pixel (1,200) -> 7.
5. key_up and key_down rise on the same cycle -> selection unchanged.
6. key_select in ACTIVE -> select_valid high exactly 1 cycle, menu_state 2, navigation ignored. menu_enable=0 -> 0. Re-enable -> 1 with selection 0. Reset while in CONFIRMED -> 0 immediately.
